// File: rtl/multiplicador_pkg.sv
// rtl/multiplicador_pkg.sv - shared widths, FSM encoding and Booth pair codes for the HI/LO multiplier
package multiplicador_pkg;

  localparam int WIDTH = 32;
  localparam int ACC_W = WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // {Q[0], q_-1} pairs that trigger an add or a subtract of M
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] q;
    logic             q_m1;
  } booth_t;

endpackage

// File: rtl/multiplicador_booth_passo.sv
// rtl/multiplicador_booth_passo.sv - one combinational radix-2 Booth step with arithmetic right shift
module multiplicador_booth_passo
  import multiplicador_pkg::*;
(
  input  booth_t           cur,
  input  logic [WIDTH-1:0] m,
  output booth_t           nxt
);

  logic [ACC_W-1:0] m_ext;
  logic [ACC_W-1:0] sum;

  always_comb begin
    m_ext = {m[WIDTH-1], m};
    case ({cur.q[0], cur.q_m1})
      BOOTH_ADD: sum = cur.acc + m_ext;
      BOOTH_SUB: sum = cur.acc - m_ext;
      default:   sum = cur.acc;
    endcase
    // 66-bit {acc, q, q_m1} shifted right with the accumulator sign replicated
    nxt.acc  = {sum[ACC_W-1], sum[ACC_W-1:1]};
    nxt.q    = {sum[0], cur.q[WIDTH-1:1]};
    nxt.q_m1 = cur.q[0];
  end

endmodule

// File: rtl/multiplicador.sv
// rtl/multiplicador.sv - sequential 32x32 signed Booth multiplier producing HI/LO for MULT
module multiplicador
  import multiplicador_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             MULT_START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             MULT_END,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] m;
  booth_t           cur;
  booth_t           nxt;

  multiplicador_booth_passo u_passo (
    .cur (cur),
    .m   (m),
    .nxt (nxt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      m        <= '0;
      cur.acc  <= '0;
      cur.q    <= '0;
      cur.q_m1 <= 1'b0;
      MULT_END <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else if (MULT_START) begin
      // a start in any state discards whatever was in flight
      state    <= RUN;
      cnt      <= CNT_W'(WIDTH);
      m        <= A;
      cur.acc  <= '0;
      cur.q    <= B;
      cur.q_m1 <= 1'b0;
      MULT_END <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      case (state)
        RUN: begin
          cur <= nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state    <= DONE;
            MULT_END <= 1'b1;
            HI       <= nxt.acc[WIDTH-1:0];
            LO       <= nxt.q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador.sv
// tb/tb_multiplicador.sv - scoreboard bench for the sequential Booth multiplier
module tb_multiplicador;

  logic        clock;
  logic        reset;
  logic        mult_start;
  logic [31:0] a;
  logic [31:0] b;
  logic        mult_end;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  longint sb[$];

  logic [31:0] da   [5] = '{32'd3, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
  logic [31:0] db   [5] = '{32'd4, 32'd3, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
  logic [63:0] dexp [5] = '{64'h0000_0000_0000_000C, 64'hFFFF_FFFF_FFFF_FFFA,
                            64'h0000_0000_0000_0001, 64'h4000_0000_0000_0000,
                            64'hC000_0000_8000_0000};

  multiplicador dut (
    .clock      (clock),
    .reset      (reset),
    .MULT_START (mult_start),
    .A          (a),
    .B          (b),
    .MULT_END   (mult_end),
    .HI         (hi),
    .LO         (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    a = x;
    b = y;
    mult_start = 1'b1;
    sb.push_back(longint'($signed(x)) * longint'($signed(y)));
    @(negedge clock);
    mult_start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (mult_end !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    mult_start = 1'b0;
    a = '0;
    b = '0;
    #1;
    checks++;
    if (mult_end !== 1'b0) begin failures++; $display("FAIL reset_end: got %b want 0", mult_end); end
    checks++;
    if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    checks++;
    if (mult_end !== 1'b0) begin failures++; $display("FAIL idle_after_reset: got %b want 0", mult_end); end
  endtask

  task automatic test_directed;
    int     lat;
    longint exp;
    logic   stable;
    for (int i = 0; i < 5; i++) begin
      pulse_start(da[i], db[i]);
      checks++;
      if (mult_end !== 1'b0 || {hi, lo} !== 64'd0) begin
        failures++;
        $display("FAIL dir%0d_cleared: got end=%b hilo=%h want end=0 hilo=0", i, mult_end, {hi, lo});
      end
      wait_done(lat);
      checks++;
      if (lat != 32) begin failures++; $display("FAIL dir%0d_latency: got %0d want 32", i, lat); end
      exp = sb.pop_front();
      checks++;
      if ({hi, lo} !== exp) begin failures++; $display("FAIL dir%0d_model: got %h want %h", i, {hi, lo}, exp); end
      checks++;
      if ({hi, lo} !== dexp[i]) begin failures++; $display("FAIL dir%0d_const: got %h want %h", i, {hi, lo}, dexp[i]); end
      stable = 1'b1;
      repeat (5) begin
        @(negedge clock);
        if (mult_end !== 1'b1 || {hi, lo} !== exp) stable = 1'b0;
      end
      checks++;
      if (!stable) begin failures++; $display("FAIL dir%0d_hold: got end=%b hilo=%h want end=1 hilo=%h", i, mult_end, {hi, lo}, exp); end
    end
  endtask

  task automatic test_restart;
    int     lat;
    longint exp;
    logic   early;
    pulse_start(32'd5, 32'd7);
    early = 1'b0;
    repeat (9) begin
      @(negedge clock);
      if (mult_end === 1'b1) early = 1'b1;
    end
    sb.delete();
    pulse_start(32'd6, 32'd6);
    wait_done(lat);
    checks++;
    if (early || lat != 32) begin failures++; $display("FAIL restart_latency: got %0d early=%b want 32 early=0", lat, early); end
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
    checks++;
    if ({hi, lo} !== exp || {hi, lo} !== 64'd36) begin failures++; $display("FAIL restart_product: got %h want %h", {hi, lo}, exp); end
  endtask

  task automatic test_async_reset;
    int     lat;
    longint exp;
    logic   spurious;
    pulse_start(32'd7, 32'd9);
    repeat (15) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mult_end !== 1'b0 || {hi, lo} !== 64'd0) begin failures++; $display("FAIL rst_midrun: got end=%b hilo=%h want 0", mult_end, {hi, lo}); end
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    spurious = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (mult_end !== 1'b0) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin failures++; $display("FAIL rst_no_end: got end=1 want 0"); end
    pulse_start(32'hFFFFFFFF, 32'd2);
    wait_done(lat);
    exp = sb.pop_front();
    checks++;
    if (lat != 32 || {hi, lo} !== exp || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      failures++;
      $display("FAIL rst_restart: got lat=%0d hilo=%h want lat=32 hilo=%h", lat, {hi, lo}, exp);
    end
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    checks++;
    if (mult_end !== 1'b0 || {hi, lo} !== 64'd0) begin failures++; $display("FAIL rst_done: got end=%b hilo=%h want 0", mult_end, {hi, lo}); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_back_to_back;
    int          lat;
    longint      exp;
    logic [31:0] x;
    logic [31:0] y;
    pulse_start(32'd11, 32'hFFFFFFF3);
    for (int i = 0; i < 3; i++) begin
      wait_done(lat);
      checks++;
      if (lat != 32) begin failures++; $display("FAIL b2b%0d_latency: got %0d want 32", i, lat); end
      exp = sb.pop_front();
      checks++;
      if ({hi, lo} !== exp) begin failures++; $display("FAIL b2b%0d_product: got %h want %h", i, {hi, lo}, exp); end
      // restart in the very cycle the result appears
      x = $urandom;
      y = $urandom;
      a = x;
      b = y;
      mult_start = 1'b1;
      sb.push_back(longint'($signed(x)) * longint'($signed(y)));
      @(negedge clock);
      mult_start = 1'b0;
      checks++;
      if (mult_end !== 1'b0) begin failures++; $display("FAIL b2b%0d_cleared: got %b want 0", i, mult_end); end
    end
    wait_done(lat);
    exp = sb.pop_front();
    checks++;
    if (lat != 32 || {hi, lo} !== exp) begin failures++; $display("FAIL b2b_last: got lat=%0d hilo=%h want lat=32 hilo=%h", lat, {hi, lo}, exp); end
  endtask

  task automatic test_random;
    int          lat;
    longint      exp;
    logic [31:0] x;
    logic [31:0] y;
    for (int i = 0; i < 1000; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 16 == 0) x = 32'h80000000;
      if (i % 23 == 0) y = 32'h80000000;
      pulse_start(x, y);
      wait_done(lat);
      checks++;
      if (lat != 32) begin failures++; $display("FAIL rnd%0d_latency: got %0d want 32", i, lat); end
      exp = sb.pop_front();
      checks++;
      if ({hi, lo} !== exp) begin failures++; $display("FAIL rnd%0d_product: a=%h b=%h got %h want %h", i, x, y, {hi, lo}, exp); end
      repeat (5) begin
        @(negedge clock);
        checks++;
        if (mult_end !== 1'b1 || {hi, lo} !== exp) begin
          failures++;
          $display("FAIL rnd%0d_hold: got end=%b hilo=%h want end=1 hilo=%h", i, mult_end, {hi, lo}, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_restart();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
